// File: rtl/hack_uart_tx.sv
// -----------------------------------------------------------------------------
// hack_uart_tx
// Memory-mapped UART transmitter on the Hack CPU data bus. A CPU store to
// DATA_ADDR queues outM[7:0] in a small byte FIFO; queued bytes are sent as
// 8N1 frames (LSB first) on txd. Back-to-back frames have no idle gap.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; clears FIFO, flags and FSM
//   addressM  CPU data word address
//   outM      CPU write data
//   writeM    CPU write strobe
//   rd_data   status word {13'b0, overflow, full, empty} when
//             addressM == STATUS_ADDR, else 16'h0000 (combinational)
//   txd       serial output, idles high
//   busy      FIFO non-empty or a frame in flight
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) is sent between
//   data bit 7 and the stop bit, giving 11-bit frames.
// -----------------------------------------------------------------------------
module hack_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [14:0] DATA_ADDR    = 15'h6002,
  parameter logic [14:0] STATUS_ADDR  = 15'h6003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] rd_data,
  output logic        txd,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic push_req, flag_clr;
  assign push_req = writeM && (addressM == DATA_ADDR);
  assign flag_clr = writeM && (addressM == STATUS_ADDR) && outM[2];

  // The upper data byte has no destination in this block.
  logic unused_hi;
  assign unused_hi = ^outM[15:8];

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             empty, full, push, pop;
  logic [7:0]       head;

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        bit_end;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (baud_q == BAUD_LAST);

  // The FSM takes the head byte in IDLE, or at the end of STOP to chain the
  // next frame with no idle gap.
  assign pop  = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  // A simultaneous pop frees a slot, so a push to a full FIFO still fits.
  assign push = push_req && (!full || pop);

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, so clearing the data would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= outM[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (push_req && !push) overflow_q <= 1'b1;
      else if (flag_clr)     overflow_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // NOTE: every next-state signal gets a default before the case so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    baud_d  = (state_q == S_IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
`ifdef UART_TX_PARITY_EN
    parity_d = pop ? ^head : parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          state_d = S_START;
          shift_d = head;
          txd_d   = 1'b0;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
        txd_d   = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
          txd_d   = parity_q;
`else
          state_d = S_STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          txd_d   = shift_q[1];  // becomes shift[0] after this shift
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        txd_d   = 1'b1;
      end
`endif
      S_STOP: if (bit_end) begin
        if (!empty) begin
          state_d = S_START;
          shift_d = head;
          txd_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: txd comes straight from a flop so it never glitches.
  // ---------------------------------------------------------------------------
  assign txd  = txd_q;
  assign busy = (state_q != S_IDLE) || !empty;

  always_comb begin
    rd_data = 16'h0000;
    if (addressM == STATUS_ADDR) rd_data = {13'b0, overflow_q, full, empty};
  end

endmodule

// File: doc/hack_uart_tx.md
Name: hack_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU alongside RAM4K. It consumes the CPU's outM/addressM/writeM. A CPU store to the data address pushes a byte into a small FIFO, and the block serialises queued bytes as 8N1 frames on txd. A status word is readable at a second address so programs can poll before writing.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..64
DATA_ADDR, 15'h6002, word address of the TX data register (write-only)
STATUS_ADDR, 15'h6003, word address of the status register (read; write clears flags)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
addressM  input  15  CPU data address
outM  input  16  CPU write data
writeM  input  1  CPU write strobe, sampled on the rising clk edge
rd_data  output  16  status word, combinational; 16'h0000 when addressM != STATUS_ADDR
txd  output  1  serial output; idles high
busy  output  1  high while the FIFO is non-empty or a frame is in flight

Behaviour:
- Reset: the clock and reset are decided as one clock, `clk`; `reset` is asynchronous and active-high. While reset is asserted:
  - txd = 1, busy = 0.
  - FIFO is emptied (count = 0); overflow flag = 0; FSM = IDLE; bit and baud counters = 0.
  - rd_data still follows the address decode and shows empty = 1.
- Push: at a rising edge with writeM=1 and addressM==DATA_ADDR, outM[7:0] is enqueued. outM[15:8] is ignored.
- Full FIFO:
  - A push to a full FIFO is dropped and sets the sticky overflow flag.
  - If a pop happens in the same cycle, the push is accepted and overflow is not set.
- Status word: rd_data = {13'b0, overflow, full, empty}. Bit 0 = empty, bit 1 = full, bit 2 = overflow.
- Flag clear: a write to STATUS_ADDR with outM[2]=1 clears overflow. All other status bits are read-only.
- FSM states: IDLE, START, DATA, STOP. One baud counter counts 0..CLKS_PER_BIT-1; each bit is held for exactly CLKS_PER_BIT cycles.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, drive txd=0 and go to START.
  - START: at the end of the bit, go to DATA with bit index 0.
  - DATA: txd = shift[0], LSB first. At the end of each bit, shift right. After bit 7, go to STOP.
  - STOP: txd=1. At the end of the bit, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Latency: for a push sampled at edge k into an empty FIFO with the FSM in IDLE, txd falls at edge k+1.
- Frame timing: exactly 10*CLKS_PER_BIT cycles from the txd falling edge to the end of the stop bit.
- busy = (FSM != IDLE) | ~empty, registered-state derived and glitch-free.
- Reset mid-frame: the frame is abandoned immediately, txd returns high asynchronously, and queued bytes are lost.
- Writes to any other address are ignored. A write whose addressM decodes to neither register has no effect.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - An even-parity bit is inserted between bit 7 and STOP, via an extra PARITY state lasting CLKS_PER_BIT cycles. The parity bit is the XOR of the 8 data bits.
  - Frame length is 11*CLKS_PER_BIT.
  - The status word is unchanged.
- Not defined: 8N1 only, and the PARITY state is not built.

Test Plan:
- CLKS_PER_BIT=4, reset released, write 16'h0055 to DATA_ADDR at edge k -> txd low from edge k+1. Bits sampled mid-bit read 1,0,1,0,1,0,1,0. txd high at edges k+37..k+40. busy drops at edge k+41.
- Write 16'hAB41 -> serialised byte is 8'h41; upper byte is ignored.
- Write 3 bytes back-to-back -> three contiguous frames with no idle cycle between a stop bit and the next start bit. Total 120 cycles of busy after the first txd fall.
- FIFO_DEPTH=8, 10 writes in consecutive cycles -> first byte popped after 1 cycle, so 9 accepted (1 in flight + 8 queued). 10th dropped; status reads 16'h0006 (overflow, full). Write 16'h0004 to STATUS_ADDR -> overflow clears, status 16'h0002.
- Assert reset at cycle 13 of a frame -> txd=1 in the same cycle without waiting for a clock. After release, busy=0 and status reads 16'h0001.
- With UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1, frame 44 cycles. Send 8'h03 -> parity bit 0.
